// File: rtl/keypad_scanner_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Holds the FSM state encoding, the key-code type and the row-priority encoder.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        WAIT_RELEASE
    } kp_state_t;

    typedef logic [3:0] key_code_t;

    // Rows are active-low; when several rows are low, the lowest index is reported.
    function automatic logic [1:0] lowest_low(input logic [NUM_ROWS-1:0] rows);
        lowest_low = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) lowest_low = 2'(i);
        end
    endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Parameterised-width two-flop synchronizer for asynchronous inputs.
// Resets to all ones, which is the idle level of the pulled-up keypad rows.
module sync2 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates active-low column strobes, debounces presses and
// releases on synchronized rows, and reports one key code per accepted press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV   = 1000,
    parameter int DEB_CYCLES = 4096,
    parameter int CNT_W      = 13
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] row_n,
    output logic [NUM_COLS-1:0] col_n,
    output key_code_t           key_code,
    output logic                key_valid,
    output logic                key_held
);

    localparam logic [CNT_W-1:0] SCAN_TC = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_TC  = CNT_W'(DEB_CYCLES - 1);

    logic [NUM_ROWS-1:0] rows_s;

    kp_state_t           state_q,    state_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic [1:0]          col_q,      col_d;
    logic [1:0]          row_idx_q,  row_idx_d;
    logic [NUM_ROWS-1:0] pat_q,      pat_d;
    key_code_t           key_code_q, key_code_d;
    logic                key_held_q, key_held_d;

    sync2 #(.W(NUM_ROWS)) u_row_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (row_n),
        .q     (rows_s)
    );

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        col_d      = col_q;
        row_idx_d  = row_idx_q;
        pat_d      = pat_q;
        key_code_d = key_code_q;
        key_held_d = key_held_q;
        key_valid  = 1'b0;

        case (state_q)
            SCAN: begin
                if (cnt_q == SCAN_TC) begin
                    cnt_d = '0;
                    if (rows_s != '1) begin
                        row_idx_d = lowest_low(rows_s);
                        pat_d     = rows_s;
                        state_d   = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DEBOUNCE: begin
                if (rows_s == pat_q) begin
                    if (cnt_q == DEB_TC) begin
                        cnt_d   = '0;
                        state_d = PRESSED;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    // A bounce aborts the candidate; the same column is rescanned from scratch.
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            end
            PRESSED: begin
                key_valid  = 1'b1;
                key_code_d = {row_idx_q, col_q};
                key_held_d = 1'b1;
                cnt_d      = '0;
                state_d    = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (rows_s == '1) begin
                    if (cnt_q == DEB_TC) begin
                        cnt_d      = '0;
                        key_held_d = 1'b0;
                        col_d      = col_q + 2'd1;
                        state_d    = SCAN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= SCAN;
            cnt_q      <= '0;
            col_q      <= 2'd0;
            row_idx_q  <= 2'd0;
            pat_q      <= '1;
            key_code_q <= '0;
            key_held_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            col_q      <= col_d;
            row_idx_q  <= row_idx_d;
            pat_q      <= pat_d;
            key_code_q <= key_code_d;
            key_held_q <= key_held_d;
        end
    end

    assign col_n    = ~(4'b0001 << col_q);
    assign key_code = key_code_q;
    assign key_held = key_held_q;

endmodule
